// File: rtl/c_add_accum_win_pkg.sv
// Shared state encoding and helper functions for the windowed accumulator.
package c_add_accum_win_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Ceiling of log2; clogb(1) = 0, clogb(2) = 1, clogb(5) = 3.
  function automatic int clogb(input int value);
    int result_v;
    result_v = 0;
    for (int i = 0; i < 31; i++) begin
      result_v = ((32'sd1 <<< i) < value) ? (i + 1) : result_v;
    end
    return result_v;
  endfunction

endpackage

// File: rtl/c_add_accum_win_nto1.sv
// Combinational unsigned sum of num_ports width-bit fields packed in data_in.
import c_add_accum_win_pkg::*;

module c_add_accum_win_nto1 #(
  parameter int width     = 1,
  parameter int num_ports = 2,
  parameter int sum_width = width + clogb(num_ports)
) (
  input  logic [width*num_ports-1:0] data_in,
  output logic [sum_width-1:0]       sum
);

  // Add every field, each zero-extended to the full sum width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < num_ports; i++) begin
      sum = sum + sum_width'(data_in[i*width +: width]);
    end
  end

endmodule

// File: rtl/c_add_accum_win.sv
// Windowed accumulator: sums num_ports fields per cycle over a programmable window.
// Define C_ADD_ACCUM_WIN_SAT_EN for a saturating accumulator with sticky sat flag.
import c_add_accum_win_pkg::*;

module c_add_accum_win #(
  parameter int width        = 1,
  parameter int num_ports    = 2,
  parameter int window_width = 8,
  parameter int acc_width    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [window_width-1:0]    window_len,
  input  logic [width*num_ports-1:0] data_in,
  output logic                       busy,
  output logic [acc_width-1:0]       result,
  output logic                       result_valid,
  input  logic                       result_ack,
  output logic                       sat
);

  localparam int sum_width = width + clogb(num_ports);
  localparam int cnt_width = clogb((32'sd1 <<< window_width) + 32'sd1);

  state_e                 state_r, state_nxt_s;
  logic                   load_s, step_s, done_s, clamp_s;
  logic [sum_width-1:0]   sum_s;
  logic [acc_width-1:0]   acc_r, acc_nxt_s, result_r;
  logic [cnt_width-1:0]   cnt_r, len_r, cnt_inc_s, len_load_s;
  logic                   busy_r, result_valid_r, sat_r;

  c_add_accum_win_nto1 #(
    .width     (width),
    .num_ports (num_ports)
  ) u_sum (
    .data_in (data_in),
    .sum     (sum_s)
  );

  assign cnt_inc_s  = cnt_r + cnt_width'(1);
  // A zero length selects the full 2^window_width window.
  assign len_load_s = (window_len == '0) ? (cnt_width'(1) << window_width)
                                         : cnt_width'(window_len);

  // Next accumulator value: clamp or wrap depending on build.
  always_comb begin
`ifdef C_ADD_ACCUM_WIN_SAT_EN
    logic [acc_width:0] wide_s;
    wide_s    = {1'b0, acc_r} + (acc_width+1)'(sum_s);
    clamp_s   = wide_s[acc_width];
    acc_nxt_s = clamp_s ? {acc_width{1'b1}} : wide_s[acc_width-1:0];
`else
    clamp_s   = 1'b0;
    acc_nxt_s = acc_r + acc_width'(sum_s);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        step_s = 1'b1;
        if (cnt_inc_s == len_r) begin
          done_s      = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (result_ack && start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_ACCUM;
        end else if (result_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r          <= '0;
      cnt_r          <= '0;
      len_r          <= '0;
      result_r       <= '0;
      sat_r          <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      if (load_s) begin
        acc_r <= '0;
        cnt_r <= '0;
        len_r <= len_load_s;
        sat_r <= 1'b0;
      end else if (step_s) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_inc_s;
        sat_r <= sat_r | clamp_s;
      end
      // The final sample lands in result on the same edge it is summed.
      if (done_s) begin
        result_r <= acc_nxt_s;
      end
      busy_r         <= (state_nxt_s != ST_IDLE);
      result_valid_r <= (state_nxt_s == ST_HOLD);
    end
  end

  assign busy         = busy_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign sat          = sat_r;

endmodule

// File: tb/tb_c_add_accum_win.sv
// Directed bench for c_add_accum_win: table-driven windows plus handshake/reset corners.
module tb_c_add_accum_win;

  logic clk, reset;

  // u0: width=2, num_ports=4, window_width=8, acc_width=16
  logic        s0, b0, rv0, sat0, r0;
  logic [7:0]  len0, d0;
  logic [15:0] res0;
  // u1: width=1, num_ports=2, window_width=3, acc_width=16
  logic        s1, b1, rv1, sat1, r1;
  logic [2:0]  len1;
  logic [1:0]  d1;
  logic [15:0] res1;
  // u2: width=2, num_ports=2, window_width=8, acc_width=4
  logic        s2, b2, rv2, sat2, r2;
  logic [7:0]  len2;
  logic [3:0]  d2;
  logic [3:0]  res2;

  int checks = 0;
  int failures = 0;
  int cnt;

  c_add_accum_win #(.width(2), .num_ports(4), .window_width(8), .acc_width(16)) u0 (
    .clk(clk), .reset(reset), .start(s0), .window_len(len0), .data_in(d0), .busy(b0),
    .result(res0), .result_valid(rv0), .result_ack(r0), .sat(sat0));
  c_add_accum_win #(.width(1), .num_ports(2), .window_width(3), .acc_width(16)) u1 (
    .clk(clk), .reset(reset), .start(s1), .window_len(len1), .data_in(d1), .busy(b1),
    .result(res1), .result_valid(rv1), .result_ack(r1), .sat(sat1));
  c_add_accum_win #(.width(2), .num_ports(2), .window_width(8), .acc_width(4)) u2 (
    .clk(clk), .reset(reset), .start(s2), .window_len(len2), .data_in(d2), .busy(b2),
    .result(res2), .result_valid(rv2), .result_ack(r2), .sat(sat2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Count negedges after the start edge until result_valid, bounded.
  task automatic wait_rv0(input int bound);
    cnt = 0;
    while (!rv0 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_u0(input logic [7:0] len, input logic [7:0] data, input logic [15:0] exp);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    @(negedge clk);
    s0 = 1'b1; len0 = len; d0 = data;
    @(negedge clk);
    s0 = 1'b0;
    chk("busy_after_start", int'(b0), 1);
    wait_rv0(n + 4);
    chk("latency", cnt, n);
    chk("result", int'(res0), int'(exp));
    chk("sat_u0", int'(sat0), 0);
    r0 = 1'b1;
    @(negedge clk);
    r0 = 1'b0;
    chk("rv_after_ack", int'(rv0), 0);
    chk("busy_after_ack", int'(b0), 0);
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // fields listed high to low; per-cycle sum times window length
    vecs[0] = '{8'd5,   8'hFF, 16'd60};    // 3+3+3+3 = 12, x5
    vecs[1] = '{8'd1,   8'h00, 16'd0};
    vecs[2] = '{8'd3,   8'hE4, 16'd18};    // 3+2+1+0 = 6, x3
    vecs[3] = '{8'd2,   8'h55, 16'd8};     // 1+1+1+1 = 4, x2
    vecs[4] = '{8'd0,   8'hFF, 16'd3072};  // 12 x 256
    vecs[5] = '{8'd255, 8'hAA, 16'd2040};  // 8 x 255

    reset = 1'b0;
    s0 = 1'b0; len0 = 8'd0; d0 = 8'd0; r0 = 1'b0;
    s1 = 1'b0; len1 = 3'd0; d1 = 2'd0; r1 = 1'b0;
    s2 = 1'b0; len2 = 8'd0; d2 = 4'd0; r2 = 1'b0;
    #1;
    chk("rst_busy", int'(b0), 0);
    chk("rst_result", int'(res0), 0);
    chk("rst_rv", int'(rv0), 0);
    chk("rst_sat", int'(sat0), 0);
    chk("rst_rv_u1", int'(rv1), 0);
    chk("rst_rv_u2", int'(rv2), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_u0(vecs[i].len, vecs[i].data, vecs[i].exp);
    end

    // Long HOLD with a stray start, then ack+start restarts back-to-back.
    @(negedge clk);
    s0 = 1'b1; len0 = 8'd2; d0 = 8'hFF;
    @(negedge clk);
    s0 = 1'b0;
    wait_rv0(8);
    chk("hold_latency", cnt, 2);
    for (int k = 0; k < 10; k++) begin
      s0 = (k == 3);
      len0 = 8'd7;
      @(negedge clk);
      chk("hold_rv", int'(rv0), 1);
      chk("hold_result", int'(res0), 24);
      chk("hold_busy", int'(b0), 1);
    end
    r0 = 1'b1; s0 = 1'b1; len0 = 8'd3; d0 = 8'h11;  // 0+1+0+1 = 2 per cycle
    @(negedge clk);
    r0 = 1'b0; s0 = 1'b0;
    chk("b2b_busy", int'(b0), 1);
    chk("b2b_rv", int'(rv0), 0);
    wait_rv0(8);
    chk("b2b_latency", cnt, 3);
    chk("b2b_result", int'(res0), 6);
    r0 = 1'b1;
    @(negedge clk);
    r0 = 1'b0;

    // result_ack in IDLE and mid-ACCUM has no effect.
    r0 = 1'b1;
    @(negedge clk);
    r0 = 1'b0;
    chk("idle_ack_busy", int'(b0), 0);
    chk("idle_ack_rv", int'(rv0), 0);
    s0 = 1'b1; len0 = 8'd4; d0 = 8'hFF;
    @(negedge clk);
    s0 = 1'b0;
    cnt = 0;
    while (!rv0 && cnt < 10) begin
      r0 = (cnt == 1);
      @(negedge clk);
      cnt++;
    end
    r0 = 1'b0;
    chk("accum_ack_latency", cnt, 4);
    chk("accum_ack_result", int'(res0), 48);
    r0 = 1'b1;
    @(negedge clk);
    r0 = 1'b0;

    // Reset in the 3rd cycle of a 6-cycle window.
    s0 = 1'b1; len0 = 8'd6; d0 = 8'hFF;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(b0), 0);
    chk("mid_rst_result", int'(res0), 0);
    chk("mid_rst_rv", int'(rv0), 0);
    chk("mid_rst_sat", int'(sat0), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_rv", int'(rv0), 0);
      chk("post_rst_busy", int'(b0), 0);
    end
    run_u0(8'd4, 8'hFF, 16'd48);

    // u1: window_len=0 with window_width=3 -> 8 samples of 2.
    @(negedge clk);
    s1 = 1'b1; len1 = 3'd0; d1 = 2'b11;
    @(negedge clk);
    s1 = 1'b0;
    cnt = 0;
    while (!rv1 && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    chk("u1_latency", cnt, 8);
    chk("u1_result", int'(res1), 16);
    chk("u1_sat", int'(sat1), 0);
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;

    // u2: acc_width=4, four samples of 6 overflow the accumulator.
    s2 = 1'b1; len2 = 8'd4; d2 = 4'hF;
    @(negedge clk);
    s2 = 1'b0;
    cnt = 0;
    while (!rv2 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("u2_latency", cnt, 4);
`ifdef C_ADD_ACCUM_WIN_SAT_EN
    chk("u2_result", int'(res2), 15);
    chk("u2_sat", int'(sat2), 1);
`else
    chk("u2_result", int'(res2), 8);
    chk("u2_sat", int'(sat2), 0);
`endif
    r2 = 1'b1;
    @(negedge clk);
    r2 = 1'b0;
    chk("u2_rv_after_ack", int'(rv2), 0);
    chk("u2_busy_after_ack", int'(b2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c_add_accum_win.md
# c_add_accum_win

Windowed accumulator that sits directly downstream of the generic n-input adder (c_add_nto1). Each cycle it sums num_ports width-bit input fields, accumulates the per-cycle sums over a programmable window of cycles, and presents the window total on a valid/ack output port. It is used for router activity statistics such as flits per window or credits returned per window.

## Interface
- width, 1, width of each input field
- num_ports, 2, number of input fields summed per cycle
- window_width, 8, width of the window length field
- acc_width, 16, accumulator and result width; must be ≥ per-cycle sum width
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous assertion, active-low
- start  in  1  begin a window; sampled only in IDLE
- window_len  in  window_width  window length in cycles; sampled with start; 0 means 2^window_width
- data_in  in  width*num_ports  input fields, [0:width*num_ports-1], field i at [i*width +: width]
- busy  out  1  high in ACCUM and HOLD
- result  out  acc_width  window total; valid only while result_valid is high
- result_valid  out  1  window total available
- result_ack  in  1  consumer accepts result
- sat  out  1  accumulator clamped during this window

## Operation
- Reset value of every output is 0: busy, result, result_valid, sat. State resets to IDLE. Cycle counter resets to 0. Accumulator resets to 0.
- Per-cycle sum is the unsigned sum of all num_ports fields. Its width is the c_add_nto1 output width. It is zero-extended to acc_width.
- IDLE:
  - When start=1, latch window_len as N (0 maps to 2^window_width).
  - Clear the accumulator and sat.
  - Go to ACCUM.
- ACCUM:
  - Each cycle, add the per-cycle sum to the accumulator and increment the cycle counter.
  - On the N-th sampled cycle, register the final total into result and go to HOLD.
- HOLD:
  - result_valid=1; result and sat are held stable.
  - On result_ack=1, go to IDLE, unless start=1 in the same cycle, in which case restart directly into ACCUM with the new window_len. This gives back-to-back windows.
- start is ignored in ACCUM. start is also ignored in HOLD unless result_ack=1 in the same cycle.
- result_ack outside HOLD is ignored.
- data_in is don't-care outside ACCUM.
- Reset asserted mid-window:
  - The partial window is discarded immediately and asynchronously.
  - No result_valid is produced for it.

## Timing
- start is high at edge t (IDLE). data_in is sampled at edges t+1 … t+N.
- result_valid rises after edge t+N. It is visible in cycle t+N+1.
- The final sample is included in result with no extra cycle.
- Minimum period between result_valid assertions with immediate ack plus start is N+1 cycles.
- busy is high from the cycle after start until the cycle after the accepting result_ack edge, unless the block restarts at that edge.

## Configuration
- C_ADD_ACCUM_WIN_SAT_EN defined:
  - The accumulator saturates at 2^acc_width−1.
  - sat is set on the first clamped add and stays set until the next window starts.
- Not defined:
  - The accumulator wraps modulo 2^acc_width.
  - sat is tied to 0.

## Structure
- State encodings (IDLE, ACCUM, HOLD) are localparams in the shared clib constants include, alongside the existing c_constants definitions.
- Use clogb from c_functions for the per-cycle sum width and for the counter width (window_width+1).
- Instantiate one c_add_nto1 sub-module, with parameters width and num_ports, for the per-cycle combinational sum.
- The FSM, counter, accumulator and output registers live in this module.

## Test plan
- width=2, num_ports=4, all fields=3, start with window_len=5 → result_valid visible 6 cycles after start; result=60; sat=0.
- window_len=0 with window_width=3, data all ones (width=1, num_ports=2) → 8 samples; result=16.
- Hold result_ack low for 10 cycles in HOLD; pulse start during HOLD → result stable; result_valid high throughout; no restart. Then ack plus start in the same cycle → new window starts immediately; busy stays 1.
- acc_width=4, width=2, num_ports=2, fields=3, window_len=4:
  - With C_ADD_ACCUM_WIN_SAT_EN → result=15, sat=1.
  - Without → result=8, sat=0.
- Assert reset in the 3rd cycle of a 6-cycle window → all outputs 0 immediately. After release, no result_valid until a new start.
- Pulse result_ack in IDLE and in ACCUM → no state change; the window total is unaffected.
